// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the 16-bit datapath.
// Sequences fetch/decode/execute and drives ALU function, mux selects and write strobes.
// Inputs : clk, reset (async, active-high), op[3:0], funct[2:0], zero
// Outputs: iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
//          alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], retire, illegal, state[3:0]
// Option : ILLEGAL_TRAP_EN -- illegal instructions halt the FSM instead of retiring as NOPs.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [2:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       retire;
    } ctl_t;

`ifdef ILLEGAL_TRAP_EN
    localparam logic   TRAP       = 1'b1;
    localparam state_t W_ILL_NEXT = HALT;
`else
    localparam logic   TRAP       = 1'b0;
    localparam state_t W_ILL_NEXT = FETCH;
`endif

    // Moore output decode for a given state; registered against the next state
    function automatic ctl_t f_decode(state_t s, logic [2:0] fn);
        ctl_t c;
        c            = '0;
        c.alucontrol = 3'b010;
        case (s)
            FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.retire = 1'b1; end
            EXECUTE: begin c.alusrca = 1'b1; c.alucontrol = fn; end
            ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
            BRANCH:  begin c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.branch = 1'b1; c.retire = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  begin c.regwrite = 1'b1; c.retire = 1'b1; end
            JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.retire = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;
    logic   r_illegal;
    logic   r_sw;
    logic   w_illegal;

    assign w_illegal = (op > 4'd5) || (op == 4'd0 && funct inside {3'b011, 3'b100, 3'b101});

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE: begin
                if (w_illegal)
                    w_next = W_ILL_NEXT;
                else
                    case (op)
                        4'd0:       w_next = EXECUTE;
                        4'd1, 4'd2: w_next = MEMADR;
                        4'd3:       w_next = BRANCH;
                        4'd4:       w_next = ADDIEX;
                        default:    w_next = JUMP;
                    endcase
            end
            MEMADR:  w_next = r_sw ? MEMWR : MEMRD;
            MEMRD:   w_next = MEMWB;
            EXECUTE: w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    // funct is only consumed when leaving DECODE, so registering the decode of
    // w_next samples it exactly there; r_sw captures the LW/SW split the same way
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_ctl     <= f_decode(FETCH, 3'b000);
            r_illegal <= 1'b0;
            r_sw      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_decode(w_next, funct);
            if (r_state == DECODE) begin
                r_sw <= (op == 4'd2);
                if (TRAP && w_illegal)
                    r_illegal <= 1'b1;
            end
        end
    end

    // Write strobes are gated by reset so nothing fires while reset is held
    assign iord       = r_ctl.iord;
    assign memwrite   = r_ctl.memwrite & ~reset;
    assign irwrite    = r_ctl.irwrite & ~reset;
    assign regwrite   = r_ctl.regwrite & ~reset;
    assign pcen       = (r_ctl.pcwrite | (r_ctl.branch & zero)) & ~reset;
    assign regdst     = r_ctl.regdst;
    assign memtoreg   = r_ctl.memtoreg;
    assign alusrca    = r_ctl.alusrca;
    assign alusrcb    = r_ctl.alusrcb;
    assign pcsrc      = r_ctl.pcsrc;
    assign alucontrol = r_ctl.alucontrol;
    // An illegal NOP retires in DECODE itself, which is only known once op is visible
    assign retire     = r_ctl.retire | (!TRAP && r_state == DECODE && w_illegal);
    assign illegal    = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller using a per-instruction state-sequence model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op = 4'd0;
    logic [2:0] funct = 3'd0;
    logic       zero = 1'b0;
    logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       retire, illegal;
    logic [3:0] state;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int st;
        bit ill;
        bit nop;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output vector for a state, straight from the per-state signal table
    function automatic logic [16:0] exp_vec(int s, bit ill, bit nop, logic [2:0] fn, logic z);
        logic [1:0] b, p;
        logic [2:0] a;
        logic       r;
        b = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
        p = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
        a = (s == 6) ? fn : (s == 8) ? 3'b110 : 3'b010;
        r = (s inside {4, 5, 7, 8, 10, 11}) || (s == 1 && nop);
        return {s == 3 || s == 5, s == 5, s == 0, s == 0 || s == 11 || (s == 8 && z),
                s == 4 || s == 7 || s == 10, s == 7, s == 4, s inside {2, 6, 8, 9},
                b, p, a, r, ill};
    endfunction

    always @(negedge clk) begin
        if (!reset && exp_q.size() != 0) begin
            ent_t e;
            e = exp_q.pop_front();
            chk("state", {28'd0, state}, e.st);
            chk("outputs", {15'd0, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
                            alusrca, alusrcb, pcsrc, alucontrol, retire, illegal},
                {15'd0, exp_vec(e.st, e.ill, e.nop, funct, zero)});
        end
    end

    // Called while the DUT is in FETCH; queues the full state walk for the instruction
    task automatic run(input logic [3:0] o, input logic [2:0] f, input logic z);
        bit bad;
        bad   = (o > 4'd5) || (o == 4'd0 && f inside {3'd3, 3'd4, 3'd5});
        op    = o;
        funct = f;
        zero  = z;
        exp_q.push_back('{0, 1'b0, 1'b0});
        if (bad) begin
            exp_q.push_back('{1, 1'b0, !TRAP});
            if (TRAP)
                for (int i = 0; i < 20; i++) exp_q.push_back('{12, 1'b1, 1'b0});
        end else begin
            exp_q.push_back('{1, 1'b0, 1'b0});
            case (o)
                4'd0: begin exp_q.push_back('{6, 1'b0, 1'b0}); exp_q.push_back('{7, 1'b0, 1'b0}); end
                4'd1: begin exp_q.push_back('{2, 1'b0, 1'b0}); exp_q.push_back('{3, 1'b0, 1'b0}); exp_q.push_back('{4, 1'b0, 1'b0}); end
                4'd2: begin exp_q.push_back('{2, 1'b0, 1'b0}); exp_q.push_back('{5, 1'b0, 1'b0}); end
                4'd3: exp_q.push_back('{8, 1'b0, 1'b0});
                4'd4: begin exp_q.push_back('{9, 1'b0, 1'b0}); exp_q.push_back('{10, 1'b0, 1'b0}); end
                default: exp_q.push_back('{11, 1'b0, 1'b0});
            endcase
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d states left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic next_fetch();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", {28'd0, state}, 0);
        chk("rst_strobes", {28'd0, irwrite, pcen, memwrite, regwrite}, 0);
        chk("rst_alusrcb", {30'd0, alusrcb}, 2'b01);
        chk("rst_aluctl", {29'd0, alucontrol}, 3'b010);
        chk("rst_illegal", {31'd0, illegal}, 0);
        reset = 1'b0;
        #1;
        chk("rel_irwrite", {31'd0, irwrite}, 1);

        run(4'd1, 3'd0, 1'b1);
        chk("lw_wb", {26'd0, state, regwrite, memtoreg}, {26'd0, 4'd4, 2'b11});
        next_fetch();
        run(4'd0, 3'b110, 1'b0);
        chk("r_wb", {26'd0, state, regdst, regwrite}, {26'd0, 4'd7, 2'b11});
        next_fetch();
        run(4'd3, 3'd0, 1'b1);
        chk("beq_taken", {26'd0, state, pcen, pcsrc}, {26'd0, 4'd8, 3'b101});
        next_fetch();
        run(4'd3, 3'd0, 1'b0);
        chk("beq_not", {26'd0, state, pcen, pcsrc}, {26'd0, 4'd8, 3'b001});
        next_fetch();
        run(4'd2, 3'd0, 1'b0);
        next_fetch();
        run(4'd5, 3'd0, 1'b0);
        chk("j", {26'd0, state, pcen, pcsrc}, {26'd0, 4'd11, 3'b110});
        next_fetch();
        run(4'd4, 3'd0, 1'b1);
        next_fetch();
        for (int i = 0; i < 4; i++) begin
            logic [2:0] fl [4];
            fl = '{3'b000, 3'b001, 3'b010, 3'b111};
            run(4'd0, fl[i], 1'b1);
            next_fetch();
        end

        if (!TRAP) begin
            run(4'd0, 3'b100, 1'b0);
            chk("nop_r", {27'd0, state, retire, illegal}, {27'd0, 4'd1, 2'b10});
            next_fetch();
            run(4'hF, 3'd0, 1'b0);
            chk("nop_op", {27'd0, state, retire, illegal}, {27'd0, 4'd1, 2'b10});
            next_fetch();
            chk("nop_back", {28'd0, state}, 0);
        end

        // Reset in MEMWR aborts the store the same cycle
        op = 4'd2;
        exp_q.push_back('{0, 1'b0, 1'b0});
        exp_q.push_back('{1, 1'b0, 1'b0});
        exp_q.push_back('{2, 1'b0, 1'b0});
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        next_fetch();
        chk("memwr_pre", {27'd0, state, memwrite}, {27'd0, 4'd5, 1'b1});
        reset = 1'b1;
        #1;
        chk("memwr_rst", {27'd0, state, memwrite}, 0);
        next_fetch();
        reset = 1'b0;
        #1;
        chk("rel_fetch", {30'd0, irwrite, pcen}, 2'b11);
        run(4'd1, 3'd0, 1'b0);
        next_fetch();

        if (TRAP) begin
            run(4'hF, 3'd0, 1'b0);
            chk("halt", {27'd0, state, illegal}, {27'd0, 4'd12, 1'b1});
            reset = 1'b1;
            #1;
            chk("halt_rst", {27'd0, state, illegal}, 0);
            next_fetch();
            reset = 1'b0;
            #1;
            run(4'd5, 3'd0, 1'b0);
            next_fetch();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the 16-bit processor datapath. Each cycle it sequences the shared 16-bit ALU, the register file, unified memory and PC through the fetch/decode/execute states. It drives the ALU's 3-bit function code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT) and all datapath mux selects and write strobes. It consumes the opcode and funct fields of the instruction register and the ALU Zero flag.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- op  input  4  instr[15:12]: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J; others illegal.
- funct  input  3  instr[2:0], R-type ALU function.
- zero  input  1  ALU Zero flag.
- iord  output  1  memory address select (0 = PC, 1 = ALUOut).
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- pcen  output  1  PC load enable = pcwrite | (branch & zero), combinational.
- regwrite  output  1  register-file write strobe.
- regdst  output  1  destination select (1 = rd, 0 = rt).
- memtoreg  output  1  writeback select (1 = MDR, 0 = ALUOut).
- alusrca  output  1  ALU A select (0 = PC, 1 = reg A).
- alusrcb  output  2  ALU B select: 00 reg B, 01 constant 1, 10 sign-ext imm, 11 sign-ext imm (branch offset).
- pcsrc  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- alucontrol  output  3  ALU function code.
- retire  output  1  one-cycle pulse in an instruction's final state.
- illegal  output  1  sticky illegal-instruction flag.
- state  output  4  current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (LW/SW), EXECUTE (R-type), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J); illegal → see Configuration.
  - MEMADR → MEMRD (LW) or MEMWR (SW).
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- Output decode is Moore on state, except pcen. Every unlisted signal is 0; alucontrol defaults to 010.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, add.
  - DECODE: alusrcb=11, add.
  - MEMADR: alusrca=1, alusrcb=10, add.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alucontrol=funct.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, alucontrol=110, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, add.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Illegal instruction: op not in the listed set, or R-type with funct ∈ {011, 100, 101}. It is detected in DECODE.
- retire is high in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP. It is also high in DECODE for an illegal instruction that is treated as a NOP.

## Timing
- Reset: state=FETCH immediately (asynchronous), illegal=0. While reset is high, irwrite, pcen, memwrite and regwrite are forced to 0; other outputs show FETCH decode.
- Reset asserted mid-instruction aborts it; no strobe fires in the reset cycle. The first fetch occurs on the first rising edge after release.
- Cycles per instruction: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal-NOP 2.
- op and funct are sampled only in DECODE (IR is stable from then on). zero is used only in BRANCH, same cycle, combinationally.
- BEQ not taken: pcen=0 in BRANCH. Taken: pcen=1.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - DECODE on an illegal instruction goes to HALT and sets illegal=1.
  - HALT drives all strobes 0 and retire 0, and stays in HALT until reset.
- ILLEGAL_TRAP_EN undefined:
  - An illegal instruction retires as a NOP: DECODE → FETCH with retire=1.
  - The PC is already incremented; illegal stays 0; HALT is unreachable.

## Test plan
- Reset held, then released with op=0001 (LW) → states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; retire pulses once; alucontrol=010 throughout.
- R-type, funct=110 → EXECUTE shows alucontrol=110, ALUWB shows regdst=1 and regwrite=1; 4 cycles total.
- BEQ with zero=1 in BRANCH → pcen=1, pcsrc=01. Repeat with zero=0 → pcen=0. Both take 3 cycles.
- SW then J back-to-back → memwrite=1 only in state 5. J gives pcsrc=10 and pcen=1 in state 11. Totals are 4+3 cycles.
- op=1111 → with ILLEGAL_TRAP_EN: state=12, illegal=1, no strobes for 20 cycles, then reset clears both. Without the macro: back to FETCH after 2 cycles, illegal=0.
- Reset asserted during MEMWR → memwrite drops the same cycle, state=0. After release, FETCH strobes appear on the next edge.
